alu_arbiter: RTL and testbench
==============================

// Module: alu_arbiter
// PURPOSE
//  Shares one 32-bit alu instance between two requesters (req0, req1), for example a
//  fetch/branch unit and an execute unit. Arbitration is round-robin with valid/ready
//  handshakes. Operands are registered before they reach the ALU. The result is returned
//  on a single response bus tagged with the requester ID. The alu sits outside this block
//  on the alu_* ports.
// PARAMETERS
//  WIDTH   32  operand/result width
//  CTRL_W  3   ALU control width (000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT)
// PORTS
//  clk          in   1       rising-edge clock
//  reset        in   1       synchronous, active-high reset
//  req0_valid   in   1       requester 0 has an operation
//  req0_ready   out  1       requester 0 operation accepted this cycle
//  req0_a       in   WIDTH   requester 0 srcA
//  req0_b       in   WIDTH   requester 0 srcB
//  req0_ctrl    in   CTRL_W  requester 0 aluCtrl
//  req1_*       --   --      same set as req0_*, for requester 1
//  alu_srcA     out  WIDTH   to alu srcA (registered)
//  alu_srcB     out  WIDTH   to alu srcB (registered)
//  alu_ctrl     out  CTRL_W  to alu aluCtrl (registered)
//  alu_rslt     in   WIDTH   from alu aluRslt
//  alu_zero     in   1       from alu zero
//  rsp_valid    out  1       response available
//  rsp_ready    in   1       consumer accepts response
//  rsp_id       out  1       requester that owns the response
//  rsp_result   out  WIDTH   captured ALU result
//  rsp_zero     out  1       captured zero flag
//  rsp_err      out  1       illegal opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - States and transitions:
//    - IDLE -> EXEC when a request is accepted.
//    - EXEC -> RESP unconditionally.
//    - RESP -> IDLE when rsp_valid && rsp_ready.
//  - IDLE:
//    - If exactly one reqN_valid is high, that requester is granted.
//    - If both are high, the requester that is not last_grant wins.
//    - reqN_ready is combinational: high only in IDLE, only for the granted N.
//    - On handshake, latch a/b/ctrl into the alu_* registers and latch N into rsp_id.
//  - EXEC: alu_* are stable. At the end of the cycle, alu_rslt -> rsp_result and
//    alu_zero -> rsp_zero.
//  - RESP:
//    - rsp_valid=1; rsp_id, rsp_result, rsp_zero and rsp_err are held stable until
//      rsp_ready.
//    - On handshake, last_grant <= rsp_id.
//  - Latency: accept in cycle N, rsp_valid in cycle N+2. Max throughput is 1 op per
//    3 cycles. No new accept occurs while in EXEC or RESP.
//  - A requester may drop valid before it is granted; no grant and no side effect follow.
//  - The alu_* registers hold their last operation after RESP; they are not cleared.
//  - Reset, including mid-operation, gives:
//    - state IDLE, last_grant=1 (req0 wins first contention);
//    - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0;
//    - alu_srcA=0, alu_srcB=0, alu_ctrl=000;
//    - req*_ready=0 during reset;
//    - an in-flight operation is discarded with no response.
// CONFIGURATION
//  ALU_ARB_OPCHECK_EN defined:
//    - A ctrl outside {000,001,010,110,111} is still accepted.
//    - alu_ctrl is forced to 000 for that operation.
//    - Its RESP has rsp_err=1, rsp_result=0, rsp_zero=1.
//  ALU_ARB_OPCHECK_EN undefined:
//    - ctrl is passed to the alu unchanged.
//    - rsp_err is tied 0.
//    - The response is whatever the alu produces.
// TESTING
//  1. req0 ADD, a=0x0AAAAA2A, b=0x04538D14 -> rsp_valid 2 cycles after accept,
//     id=0, result=0x0EFE373E, zero=0.
//  2. Both valid, req0 SUB and req1 AND with the test-1 operands ->
//     first response id=0, result=0x06571D16; then id=1, result=0x00028800.
//     The order alternates on the next contention.
//  3. req1 SLT with the test-1 operands, rsp_ready held low 5 cycles ->
//     rsp_valid/result=0/zero=1 stay stable, req*_ready stay 0, then complete.
//  4. reset asserted in EXEC -> next cycle rsp_valid=0, alu_*=0, state IDLE.
//     After reset, a new req0 ADD completes normally.
//  5. ctrl=101: with the macro -> rsp_err=1, result=0, zero=1, alu_ctrl driven 000.
//     Without the macro -> rsp_err=0 and alu_ctrl=101.
//  6. Only req1 valid while last_grant=0 -> req1 is granted immediately (no idle
//     cycle). req0 pulsing valid for 1 cycle during RESP -> ignored.

Source files
------------

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one external ALU between two requesters. Accept to rsp_valid is 2 cycles, one op in flight,
// and a stalled rsp_ready holds the response and blocks new accepts. Optional opcode checking: define ALU_ARB_OPCHECK_EN.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  output logic [WIDTH-1:0]  alu_srcA,
  output logic [WIDTH-1:0]  alu_srcB,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [WIDTH-1:0]  alu_rslt,
  input  logic              alu_zero,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic              rsp_zero,
  output logic              rsp_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } stateT;

  typedef struct packed {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [CTRL_W-1:0] ctrl;
  } opT;

  stateT state;
  logic  lastGrant;
  logic  grant1;
  logic  accept;
  opT    selOp;

  // req1 wins when it is alone, or when both ask and req0 was served last.
  assign grant1     = req1_valid & (~req0_valid | ~lastGrant);
  assign req0_ready = ~reset & (state == IDLE) & req0_valid & ~grant1;
  assign req1_ready = ~reset & (state == IDLE) & grant1;
  assign accept     = req0_ready | req1_ready;

  always_comb begin
    selOp = grant1 ? opT'{req1_a, req1_b, req1_ctrl} : opT'{req0_a, req0_b, req0_ctrl};
  end

`ifdef ALU_ARB_OPCHECK_EN
  logic selIllegal;
  logic errPend;
  logic errReg;

  always_comb begin
    selIllegal = !(selOp.ctrl inside {CTRL_W'(0), CTRL_W'(1), CTRL_W'(2), CTRL_W'(6), CTRL_W'(7)});
  end

  assign rsp_err = errReg;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lastGrant  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      alu_srcA   <= '0;
      alu_srcB   <= '0;
      alu_ctrl   <= '0;
`ifdef ALU_ARB_OPCHECK_EN
      errPend    <= 1'b0;
      errReg     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_srcA <= selOp.a;
            alu_srcB <= selOp.b;
`ifdef ALU_ARB_OPCHECK_EN
            alu_ctrl <= selIllegal ? '0 : selOp.ctrl;
            errPend  <= selIllegal;
`else
            alu_ctrl <= selOp.ctrl;
`endif
            rsp_id   <= grant1;
            state    <= EXEC;
          end
        end
        EXEC: begin
          rsp_result <= alu_rslt;
          rsp_zero   <= alu_zero;
`ifdef ALU_ARB_OPCHECK_EN
          // An illegal op ran as AND; its response is replaced with a clean error result.
          if (errPend) begin
            rsp_result <= '0;
            rsp_zero   <= 1'b1;
          end
          errReg     <= errPend;
`endif
          rsp_valid  <= 1'b1;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            lastGrant <= rsp_id;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU hung on the alu_* ports.
module tb_alu_arbiter;

  localparam logic [31:0] OPA = 32'h0AAA_AA2A;
  localparam logic [31:0] OPB = 32'h0453_8D14;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [2:0]  req0_ctrl = '0, req1_ctrl = '0;
  logic [31:0] alu_srcA, alu_srcB, alu_rslt;
  logic [2:0]  alu_ctrl;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready = 1'b1, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  int checks = 0;
  int failures = 0;

  alu_arbiter #(.WIDTH(32), .CTRL_W(3)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_ctrl(req1_ctrl),
    .alu_srcA(alu_srcA), .alu_srcB(alu_srcB), .alu_ctrl(alu_ctrl), .alu_rslt(alu_rslt), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_ctrl)
      3'b000:  alu_rslt = alu_srcA & alu_srcB;
      3'b001:  alu_rslt = alu_srcA | alu_srcB;
      3'b010:  alu_rslt = alu_srcA + alu_srcB;
      3'b110:  alu_rslt = alu_srcA - alu_srcB;
      3'b111:  alu_rslt = {31'b0, $signed(alu_srcA) < $signed(alu_srcB)};
      default: alu_rslt = 32'hFFFF_FFFF;
    endcase
  end
  assign alu_zero = (alu_rslt == 32'h0);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic waitAccept(input string tag, input bit who);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (who ? req1_ready : req0_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    if (who) req1_valid = 1'b0;
    else     req0_valid = 1'b0;
    check({tag, " accepted"}, 32'(got), 32'd1);
  endtask

  task automatic waitRsp(input string tag, input bit expId, input logic [31:0] expRes,
                         input bit expZero, input bit expErr);
    bit got = 1'b0;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1'b1;
        check({tag, " id"}, 32'(rsp_id), 32'(expId));
        check({tag, " result"}, rsp_result, expRes);
        check({tag, " zero"}, 32'(rsp_zero), 32'(expZero));
        check({tag, " err"}, 32'(rsp_err), 32'(expErr));
      end
      @(posedge clk); #1;
    end
    check({tag, " rsp seen"}, 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with both requesters already asking.
    req0_a = OPA; req0_b = OPB; req0_ctrl = 3'b110;
    req1_a = OPA; req1_b = OPB; req1_ctrl = 3'b000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst req0_ready", 32'(req0_ready), 32'd0);
    check("rst req1_ready", 32'(req1_ready), 32'd0);
    check("rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst rsp_id", 32'(rsp_id), 32'd0);
    check("rst rsp_result", rsp_result, 32'd0);
    check("rst rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst rsp_err", 32'(rsp_err), 32'd0);
    check("rst alu_srcA", alu_srcA, 32'd0);
    check("rst alu_srcB", alu_srcB, 32'd0);
    check("rst alu_ctrl", 32'(alu_ctrl), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // First contention after reset: req0 wins.
    @(negedge clk);
    check("c1 req0_ready", 32'(req0_ready), 32'd1);
    check("c1 req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    waitRsp("c1 sub", 1'b0, 32'h0657_1D16, 1'b0, 1'b0);
    waitAccept("c1 and", 1'b1);
    waitRsp("c1 and", 1'b1, 32'h0002_8800, 1'b0, 1'b0);

    // Single req0 ADD with exact latency.
    req0_ctrl = 3'b010; req0_valid = 1'b1;
    @(negedge clk);
    check("add req0_ready", 32'(req0_ready), 32'd1);
    check("add req1_ready", 32'(req1_ready), 32'd0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(negedge clk);
    check("add exec rsp_valid", 32'(rsp_valid), 32'd0);
    check("add alu_srcA", alu_srcA, OPA);
    check("add alu_srcB", alu_srcB, OPB);
    check("add alu_ctrl", 32'(alu_ctrl), 32'd2);
    @(posedge clk); #1;
    @(negedge clk);
    check("add rsp_valid N+2", 32'(rsp_valid), 32'd1);
    check("add id", 32'(rsp_id), 32'd0);
    check("add result", rsp_result, 32'h0EFE_373E);
    check("add zero", 32'(rsp_zero), 32'd0);
    @(posedge clk); #1;

    // Second contention: req0 was last, so req1 wins this time.
    req0_ctrl = 3'b001; req1_ctrl = 3'b010;
    req0_valid = 1'b1; req1_valid = 1'b1;
    @(negedge clk);
    check("c2 req0_ready", 32'(req0_ready), 32'd0);
    check("c2 req1_ready", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    waitRsp("c2 add", 1'b1, 32'h0EFE_373E, 1'b0, 1'b0);
    waitAccept("c2 or", 1'b0);
    waitRsp("c2 or", 1'b0, 32'h0EFB_AF3E, 1'b0, 1'b0);

    // req1 alone while req0 was last: granted in the first idle cycle; then a stalled SLT.
    req1_ctrl = 3'b111; req1_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    check("slt req1 immediate", 32'(req1_ready), 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      req0_valid = (i == 1);
      @(negedge clk);
      check("stall rsp_valid", 32'(rsp_valid), 32'd1);
      check("stall id", 32'(rsp_id), 32'd1);
      check("stall result", rsp_result, 32'd0);
      check("stall zero", 32'(rsp_zero), 32'd1);
      check("stall req0_ready", 32'(req0_ready), 32'd0);
      check("stall req1_ready", 32'(req1_ready), 32'd0);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    check("stall release rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post pulse rsp_valid", 32'(rsp_valid), 32'd0);
      check("post hold alu_ctrl", 32'(alu_ctrl), 32'd7);
      check("post hold alu_srcA", alu_srcA, OPA);
      @(posedge clk); #1;
    end

    // Reset while an op is in EXEC: it must vanish.
    req0_a = 32'd1; req0_b = 32'd2; req0_ctrl = 3'b010; req0_valid = 1'b1;
    waitAccept("mid rst op", 1'b0);
    reset = 1'b1;
    req0_a = 32'd5; req0_b = 32'd7; req0_valid = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid rst alu_srcA", alu_srcA, 32'd0);
    check("mid rst alu_srcB", alu_srcB, 32'd0);
    check("mid rst alu_ctrl", 32'(alu_ctrl), 32'd0);
    check("mid rst req0_ready", 32'(req0_ready), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    waitAccept("after rst add", 1'b0);
    waitRsp("after rst add", 1'b0, 32'd12, 1'b0, 1'b0);

    // Illegal opcode 101.
    req0_a = OPA; req0_b = OPB; req0_ctrl = 3'b101; req0_valid = 1'b1;
    waitAccept("bad op", 1'b0);
    @(negedge clk);
`ifdef ALU_ARB_OPCHECK_EN
    check("bad op alu_ctrl", 32'(alu_ctrl), 32'd0);
    @(posedge clk); #1;
    waitRsp("bad op", 1'b0, 32'd0, 1'b1, 1'b1);
`else
    check("bad op alu_ctrl", 32'(alu_ctrl), 32'd5);
    @(posedge clk); #1;
    waitRsp("bad op", 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
